fp32_mul_byte_bridge: RTL

//   Byte-stream front end for the Chisel FP32 Multiply core. Assembles two 32-bit

---
 rtl/fp32_mul_pkg.sv | 15 +
 rtl/fp32_result_serializer.sv | 56 +++++
 rtl/fp32_mul_byte_bridge.sv | 113 +++++++++++
 3 files changed

// File: rtl/fp32_mul_pkg.sv
// Shared types and constants for the FP32 Multiply byte-stream bridge.
package fp32_mul_pkg;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    SEND  = 2'd3
  } state_e;

  localparam logic [31:0] FP32_QNAN     = 32'h7FC0_0000;
  localparam int          OPERAND_BYTES = 8;
  localparam int          RESULT_BYTES  = 4;

endpackage

// File: rtl/fp32_result_serializer.sv
// Holds a 32-bit result and hands it out MSB byte first over a valid/ready port.
module fp32_result_serializer
  import fp32_mul_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        load_i,
  input  logic [31:0] res_i,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [7:0]  out_byte,
  output logic        done_o
);

  logic [31:0] res_q, res_d;
  logic [1:0]  send_cnt_q, send_cnt_d;
  logic        valid_q, valid_d;
  logic        hs;

  assign hs        = valid_q & out_ready;
  assign done_o    = hs && (send_cnt_q == 2'(RESULT_BYTES - 1));
  assign out_valid = valid_q;
  assign out_byte  = res_q[31:24];

  always_comb begin
    res_d      = res_q;
    send_cnt_d = send_cnt_q;
    valid_d    = valid_q;
    if (load_i) begin
      res_d      = res_i;
      send_cnt_d = '0;
      valid_d    = 1'b1;
    end else if (hs) begin
      res_d = {res_q[23:0], 8'h00};
      if (done_o) begin
        send_cnt_d = '0;
        valid_d    = 1'b0;
      end else begin
        send_cnt_d = send_cnt_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      res_q      <= '0;
      send_cnt_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      res_q      <= res_d;
      send_cnt_q <= send_cnt_d;
      valid_q    <= valid_d;
    end
  end

endmodule

// File: rtl/fp32_mul_byte_bridge.sv
// Byte-stream front end for the FP32 Multiply core: gathers operands, issues them,
// and returns the result (or a timeout qNaN) as four bytes.
//   state | meaning
//   LOAD  | shifting in 8 operand bytes
//   ISSUE | operand pair offered to the core
//   WAIT  | waiting for the core result, bounded by TIMEOUT
//   SEND  | result bytes streaming out
module fp32_mul_byte_bridge
  import fp32_mul_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [7:0]        in_byte,
  output logic              in_ready,
  output logic [DATA_W-1:0] io_a_bits,
  output logic [DATA_W-1:0] io_b_bits,
  output logic              io_in_valid,
  input  logic              io_in_ready,
  input  logic              io_out_valid,
  input  logic [DATA_W-1:0] io_out_bits,
  output logic              out_valid,
  output logic [7:0]        out_byte,
  input  logic              out_ready,
  output logic              busy,
  output logic              timeout_err
);

  state_e              state_q;
  logic [2:0]          byte_cnt_q;
  logic [7:0]          wait_cnt_q;
  logic [2*DATA_W-1:0] opnd_q;
  logic                timeout_err_q;

  logic              timeout_hit;
  logic              ser_load;
  logic [DATA_W-1:0] ser_res;
  logic              ser_done;

  assign in_ready    = (state_q == LOAD);
  assign io_in_valid = (state_q == ISSUE);
  assign busy        = (state_q != LOAD);
  assign timeout_err = timeout_err_q;
  assign io_a_bits   = opnd_q[2*DATA_W-1:DATA_W];
  assign io_b_bits   = opnd_q[DATA_W-1:0];

  assign timeout_hit = (state_q == WAIT) && !io_out_valid
                       && (wait_cnt_q == 8'(TIMEOUT - 1));
  // A core answering in the same cycle it accepts is captured straight from ISSUE.
  assign ser_load = ((state_q == ISSUE) && io_in_ready && io_out_valid)
                    || ((state_q == WAIT) && (io_out_valid || timeout_hit));
  assign ser_res  = timeout_hit ? FP32_QNAN : io_out_bits;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= LOAD;
      byte_cnt_q    <= '0;
      wait_cnt_q    <= '0;
      opnd_q        <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      case (state_q)
        LOAD: begin
          if (in_valid) begin
            opnd_q        <= {opnd_q[2*DATA_W-9:0], in_byte};
            timeout_err_q <= 1'b0;
            if (byte_cnt_q == 3'(OPERAND_BYTES - 1)) begin
              byte_cnt_q <= '0;
              state_q    <= ISSUE;
            end else begin
              byte_cnt_q <= byte_cnt_q + 3'd1;
            end
          end
        end
        ISSUE: begin
          if (io_in_ready) begin
            wait_cnt_q <= '0;
            state_q    <= io_out_valid ? SEND : WAIT;
          end
        end
        WAIT: begin
          if (io_out_valid) begin
            state_q <= SEND;
          end else if (timeout_hit) begin
            timeout_err_q <= 1'b1;
            state_q       <= SEND;
          end else begin
            wait_cnt_q <= wait_cnt_q + 8'd1;
          end
        end
        SEND: begin
          if (ser_done) state_q <= LOAD;
        end
        default: state_q <= LOAD;
      endcase
    end
  end

  fp32_result_serializer u_ser (
    .clock     (clock),
    .reset     (reset),
    .load_i    (ser_load),
    .res_i     (ser_res),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_byte  (out_byte),
    .done_o    (ser_done)
  );

endmodule
